switch_debouncer: RTL and testbench

Two-channel synchroniser and debouncer for Basys3 slide switches and push-buttons. It sits directly upstream of the basic-gate exercises and drives their `A`/`B` inputs with clean, metastability-free levels. It also provides one-cycle rise and fall pulses for later counter and FSM exercises. Both channels are identical and fully independent.

---
 rtl/switch_debouncer.sv | 128 ++++++++++++
 tb/tb_switch_debouncer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Two-channel 2-FF synchroniser plus debouncer with registered level and
// one-cycle rise/fall pulses. The channels are identical and share no logic.
module switch_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] raw_in,
  output logic [1:0] db_out,
  output logic [1:0] rise_pulse,
  output logic [1:0] fall_pulse
);

  localparam int unsigned NCH = 2;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_TO_HIGH,
    ST_HIGH,
    ST_TO_LOW
  } state_t;

  logic [1:0]       s1;
  logic [1:0]       s2;
  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [1:0]       db_d;
  logic [1:0]       rise_d;
  logic [1:0]       fall_d;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Per-channel qualification: a new level must be seen on STABLE_CYCLES
  // consecutive synchronised samples before it is committed.
  always_comb begin
    db_d   = db_out;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      case (state_q[ch])
        ST_LOW: begin
          if (s2[ch]) begin
            state_d[ch] = ST_TO_HIGH;
            cnt_d[ch]   = CNT_ONE;
          end else begin
            cnt_d[ch]   = '0;
          end
        end
        ST_TO_HIGH: begin
          if (!s2[ch]) begin
            state_d[ch] = ST_LOW;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_HIGH;
            cnt_d[ch]   = '0;
            db_d[ch]    = 1'b1;
            rise_d[ch]  = 1'b1;
          end else begin
            cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s2[ch]) begin
            state_d[ch] = ST_TO_LOW;
            cnt_d[ch]   = CNT_ONE;
          end else begin
            cnt_d[ch]   = '0;
          end
        end
        ST_TO_LOW: begin
          if (s2[ch]) begin
            state_d[ch] = ST_HIGH;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_LOW;
            cnt_d[ch]   = '0;
            db_d[ch]    = 1'b0;
            fall_d[ch]  = 1'b1;
          end else begin
            cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
          end
        end
        default: begin
          state_d[ch] = ST_LOW;
          cnt_d[ch]   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; reset forces LOW without pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= ST_LOW;
        cnt_q[ch]   <= '0;
      end
      db_out     <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      db_out     <= db_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4. A window model
// (a level commits once the last S synchronised samples all differ from it)
// is compared every cycle; literal checks pin the expected latencies.
module tb_switch_debouncer;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] raw_in;
  logic [1:0] db_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;

  int checks   = 0;
  int failures = 0;

  switch_debouncer #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  // Model: two-sample delay line, then a window of the last S samples per channel.
  logic [1:0]   m_s1, m_s2, m_db, m_rise, m_fall;
  logic [S-1:0] m_hist [2];

  function automatic logic qualifies(input logic [S-1:0] hist, input logic smp,
                                     input logic db);
    logic [S-1:0] win;
    win = {hist[S-2:0], smp};
    return win == {S{~db}};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_s1      <= '0;
      m_s2      <= '0;
      m_db      <= '0;
      m_rise    <= '0;
      m_fall    <= '0;
      m_hist[0] <= '0;
      m_hist[1] <= '0;
    end else begin
      m_s1   <= raw_in;
      m_s2   <= m_s1;
      m_rise <= '0;
      m_fall <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        m_hist[ch] <= {m_hist[ch][S-2:0], m_s2[ch]};
        if (qualifies(m_hist[ch], m_s2[ch], m_db[ch])) begin
          m_db[ch] <= ~m_db[ch];
          if (m_db[ch]) m_fall[ch] <= 1'b1;
          else          m_rise[ch] <= 1'b1;
        end
      end
    end
  end

  // Advance one cycle and compare all outputs against the model.
  task automatic cyc();
    @(negedge clk);
    checks++;
    if ({db_out, rise_pulse, fall_pulse} !== {m_db, m_rise, m_fall}) begin
      failures++;
      $display("FAIL model_cmp t=%0t db=%b rise=%b fall=%b required db=%b rise=%b fall=%b",
               $time, db_out, rise_pulse, fall_pulse, m_db, m_rise, m_fall);
    end
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b required=%b", name, $time, act, exp);
    end
  endtask

  logic [6:0] bounce0;
  logic [7:0] bounce1;

  initial begin
    rst    = 1'b1;
    raw_in = 2'b11;

    // 1: reset held 3 cycles with inputs high, then requalify.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_outputs", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_release_wait", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    end
    cyc();
    chk("rst_release_rise", {db_out, rise_pulse, fall_pulse}, 6'b111100);
    cyc();
    chk("rst_release_after", {db_out, rise_pulse, fall_pulse}, 6'b110000);
    raw_in = 2'b00;
    cycn(5);
    cyc();
    chk("both_fall", {db_out, rise_pulse, fall_pulse}, 6'b000011);
    cycn(4);

    // 2: clean press and release on channel 0.
    raw_in = 2'b01;
    cycn(5);
    chk("press_edge4", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    cyc();
    chk("press_edge5", {db_out, rise_pulse, fall_pulse}, 6'b010100);
    cyc();
    chk("press_edge6", {db_out, rise_pulse, fall_pulse}, 6'b010000);
    cycn(13);
    raw_in = 2'b00;
    cycn(5);
    chk("release_edge24", {db_out, rise_pulse, fall_pulse}, 6'b010000);
    cyc();
    chk("release_edge25", {db_out, rise_pulse, fall_pulse}, 6'b000001);
    cyc();
    chk("release_edge26", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    cycn(4);

    // 3: bounce 1,1,0,1,1,1,0 then steady 1 (bit 6 applied first).
    bounce0 = 7'b1101110;
    for (int i = 6; i >= 0; i--) begin
      raw_in = {1'b0, bounce0[i]};
      cyc();
      chk("bounce_quiet", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    end
    raw_in = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bounce_settle", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    end
    cyc();
    chk("bounce_rise", {db_out, rise_pulse, fall_pulse}, 6'b010100);
    raw_in = 2'b00;
    cycn(8);

    // 4: 3-cycle glitch on channel 1 is rejected.
    raw_in = 2'b10;
    cycn(3);
    raw_in = 2'b00;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("glitch_reject", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    end

    // 5: reset mid-qualification, then reset while high.
    raw_in = 2'b01;
    cycn(3);
    rst = 1'b1;
    cyc();
    chk("rst_midqual", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("requal_wait", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    end
    cyc();
    chk("requal_rise", {db_out, rise_pulse, fall_pulse}, 6'b010100);
    cycn(2);
    rst = 1'b1;
    cyc();
    chk("rst_high_nofall", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("requal2_wait", {db_out, rise_pulse, fall_pulse}, 6'b000000);
    end
    cyc();
    chk("requal2_rise", {db_out, rise_pulse, fall_pulse}, 6'b010100);
    raw_in = 2'b00;
    cycn(8);

    // 6: simultaneous rise, then channel 1 bounces low while channel 0 holds.
    raw_in = 2'b11;
    cycn(5);
    cyc();
    chk("simul_rise", {db_out, rise_pulse, fall_pulse}, 6'b111100);
    bounce1 = 8'b01001101;
    for (int i = 7; i >= 0; i--) begin
      raw_in = {bounce1[i], 1'b1};
      cyc();
      chk("ch0_undisturbed", {db_out[0], rise_pulse[0], fall_pulse[0], 3'b000}, 6'b100000);
    end
    raw_in = 2'b11;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("ch_steady_high", {db_out, rise_pulse, fall_pulse}, 6'b110000);
    end

    // Toggling every cycle never changes the outputs.
    for (int i = 0; i < 12; i++) begin
      raw_in = (i % 2 == 0) ? 2'b00 : 2'b11;
      cyc();
      chk("toggle_ignored", {db_out, rise_pulse, fall_pulse}, 6'b110000);
    end
    raw_in = 2'b11;
    cycn(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
